// File: rtl/fifo_burst_reader_pkg.sv
// Shared constants and state encoding for the async-FIFO read-side burst consumer.
package fifo_burst_reader_pkg;

    localparam int DATASIZE     = 8;
    localparam int READ_PERIOD  = 1;
    localparam int BURST_LENGTH = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } rd_state_t;

endpackage

// File: rtl/fifo_burst_reader_pacer.sv
// fifo_rd_pacer: counts idle cycles between reads and flags the last one.
module fifo_rd_pacer #(
    parameter int READ_PERIOD = fifo_burst_reader_pkg::READ_PERIOD
) (
    input  logic rclk,
    input  logic rrst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int GAP_W = (READ_PERIOD > 1) ? $clog2(READ_PERIOD) : 1;
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((READ_PERIOD > 0) ? READ_PERIOD - 1 : 0);

    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (clear) begin
            gap_cnt_d = '0;
        end else if (enable) begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign expire = (gap_cnt_q == LAST_GAP);

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains one burst from the async FIFO per start pulse, paced by idle gaps, into a valid/ready register.
// Optional running checksum of popped words is enabled by defining FIFO_RD_CHECKSUM_EN.
module fifo_burst_reader #(
    parameter int DATASIZE     = fifo_burst_reader_pkg::DATASIZE,
    parameter int READ_PERIOD  = fifo_burst_reader_pkg::READ_PERIOD,
    parameter int BURST_LENGTH = fifo_burst_reader_pkg::BURST_LENGTH
) (
    input  logic                          rclk,
    input  logic                          rrst_n,
    input  logic                          start,
    input  logic                          rempty,
    input  logic [DATASIZE-1:0]           rdata,
    output logic                          rinc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATASIZE-1:0]           out_data,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(BURST_LENGTH):0] word_cnt,
    output logic [DATASIZE-1:0]           checksum
);

    import fifo_burst_reader_pkg::*;

    localparam int CNT_W = $clog2(BURST_LENGTH) + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_LENGTH - 1);

    rd_state_t           state_q, state_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [DATASIZE-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                pop;
    logic                gap_clear, gap_en, gap_expire;

    fifo_rd_pacer #(
        .READ_PERIOD (READ_PERIOD)
    ) u_pacer (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .clear  (gap_clear),
        .enable (gap_en),
        .expire (gap_expire)
    );

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        pop         = 1'b0;
        gap_clear   = 1'b1;
        gap_en      = 1'b0;

        // An accept empties the register; a pop below may reload it in the same cycle.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    word_cnt_d = '0;
                    state_d    = (READ_PERIOD == 0) ? READ : GAP;
                end
            end
            GAP: begin
                gap_clear = 1'b0;
                gap_en    = 1'b1;
                if (gap_expire) begin
                    state_d = READ;
                end
            end
            READ: begin
                pop = !rempty && (!out_valid_q || out_ready);
                if (pop) begin
                    out_data_d  = rdata;
                    out_valid_d = 1'b1;
                    word_cnt_d  = word_cnt_q + CNT_W'(1);
                    if (word_cnt_q == LAST_WORD) begin
                        state_d = DONE;
                    end else if (READ_PERIOD != 0) begin
                        state_d = GAP;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef FIFO_RD_CHECKSUM_EN
    logic [DATASIZE-1:0] checksum_q, checksum_d;
    logic                sum_clear;

    assign sum_clear = (state_q == IDLE) && start;

    always_comb begin
        checksum_d = checksum_q;
        if (sum_clear) begin
            checksum_d = '0;
        end else if (pop) begin
            checksum_d = checksum_q + rdata;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign rinc      = pop;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural show-ahead FIFO on the read side.
module tb_fifo_burst_reader;

    logic       rclk;
    logic       rrst_n;
    logic       start;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic       done;
    logic [2:0] word_cnt;
    logic [7:0] checksum;

    int errors = 0;
    int checks = 0;

    fifo_burst_reader #(
        .DATASIZE     (8),
        .READ_PERIOD  (1),
        .BURST_LENGTH (4)
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .start     (start),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .word_cnt  (word_cnt),
        .checksum  (checksum)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Show-ahead FIFO model: writes from the stimulus, pops on rinc at the clock edge.
    logic [7:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr;

    assign rempty = (wr_ptr == rd_ptr);
    assign rdata  = mem[rd_ptr % 64];

    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) rd_ptr <= 0;
        else if (rinc) rd_ptr <= rd_ptr + 1;
    end

    typedef struct {
        logic       start;
        logic       out_ready;
        logic       rinc;
        logic       out_valid;
        logic       busy;
        logic       done;
        logic [2:0] word_cnt;
        logic [7:0] out_data;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge rclk);
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr % 64] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    // Leaves the caller at the falling edge of the first GAP cycle.
    task automatic start_burst();
        tick();
        start = 1'b1;
        #1;
        tick();
        start = 1'b0;
    endtask

    task automatic run(input int n, output int nr, output int nd);
        nr = 0;
        nd = 0;
        repeat (n) begin
            tick();
            #1;
            nr += int'(rinc);
            nd += int'(done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nr, nd, nr2, nd2;
        logic all_idle;
        logic stable;
        logic reached;
        logic [7:0] exp_sum;

        //                start ready  rinc valid busy done  wc     data
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 8'h11};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'h11};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 8'h22};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 8'h22};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 8'h33};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 8'h33};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 8'h44};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 8'h44};

        rrst_n    = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        wr_ptr    = 0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (2) tick();
        rrst_n = 1'b1;

        // Test 1: paced burst of four, cycle by cycle.
        for (int i = 0; i < 11; i++) begin
            tick();
            start     = vecs[i].start;
            out_ready = vecs[i].out_ready;
            #1;
            check($sformatf("t1.v%0d.rinc", i),      32'(rinc),      32'(vecs[i].rinc));
            check($sformatf("t1.v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].out_valid));
            check($sformatf("t1.v%0d.busy", i),      32'(busy),      32'(vecs[i].busy));
            check($sformatf("t1.v%0d.done", i),      32'(done),      32'(vecs[i].done));
            check($sformatf("t1.v%0d.word_cnt", i),  32'(word_cnt),  32'(vecs[i].word_cnt));
            check($sformatf("t1.v%0d.out_data", i),  32'(out_data),  32'(vecs[i].out_data));
        end
`ifdef FIFO_RD_CHECKSUM_EN
        exp_sum = 8'hAA;
`else
        exp_sum = 8'h00;
`endif
        check("t1.checksum", 32'(checksum), 32'(exp_sum));

        // Test 2: empty FIFO stalls READ; the first word is popped the cycle it appears.
        start_burst();
        all_idle = 1'b1;
        repeat (10) begin
            tick();
            #1;
            if (rinc) all_idle = 1'b0;
        end
        check("t2.no_rinc_while_empty", 32'(all_idle), 32'(1'b1));
        tick();
        push(8'h5A);
        #1;
        check("t2.pop_first_nonempty", 32'(rinc), 32'(1'b1));
        tick();
        #1;
        check("t2.out_data", 32'(out_data), 32'h5A);
        check("t2.word_cnt", 32'(word_cnt), 32'd1);
        push(8'h5B); push(8'h5C); push(8'h5D);
        run(12, nr, nd);
        check("t2.rest_pops", 32'(nr), 32'd3);
        check("t2.done_pulses", 32'(nd), 32'd1);
        check("t2.word_cnt_end", 32'(word_cnt), 32'd4);

        // Test 3: backpressure holds the output word; release pops and accepts together.
        push(8'h61); push(8'h62); push(8'h63); push(8'h64);
        out_ready = 1'b0;
        start_burst();
        tick();
        #1;
        check("t3.first_pop", 32'(rinc), 32'(1'b1));
        stable = 1'b1;
        repeat (5) begin
            tick();
            #1;
            if (rinc || out_data !== 8'h61 || !out_valid) stable = 1'b0;
        end
        check("t3.stall_stable", 32'(stable), 32'(1'b1));
        tick();
        out_ready = 1'b1;
        #1;
        check("t3.pop_on_release", 32'(rinc), 32'(1'b1));
        tick();
        #1;
        check("t3.next_data", 32'(out_data), 32'h62);
        check("t3.next_valid", 32'(out_valid), 32'(1'b1));
        run(10, nr, nd);
        check("t3.rest_pops", 32'(nr), 32'd2);
        check("t3.done_pulses", 32'(nd), 32'd1);

        // Test 4: checksum wraps modulo 256.
        push(8'h01); push(8'h02); push(8'hFF); push(8'h00);
        start_burst();
        run(12, nr, nd);
        check("t4.pops", 32'(nr), 32'd4);
        check("t4.done_pulses", 32'(nd), 32'd1);
`ifdef FIFO_RD_CHECKSUM_EN
        exp_sum = 8'h02;
`else
        exp_sum = 8'h00;
`endif
        check("t4.checksum", 32'(checksum), 32'(exp_sum));

        // Test 5: reset mid-burst clears everything; the next burst counts from zero.
        push(8'h71); push(8'h72); push(8'h73); push(8'h74);
        start_burst();
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            tick();
            #1;
            if (word_cnt == 3'd2) reached = 1'b1;
        end
        check("t5.reached_wc2", 32'(reached), 32'(1'b1));
        rrst_n = 1'b0;
        wr_ptr = 0;
        #1;
        check("t5.rst.rinc",      32'(rinc),      32'd0);
        check("t5.rst.out_valid", 32'(out_valid), 32'd0);
        check("t5.rst.out_data",  32'(out_data),  32'd0);
        check("t5.rst.done",      32'(done),      32'd0);
        check("t5.rst.busy",      32'(busy),      32'd0);
        check("t5.rst.word_cnt",  32'(word_cnt),  32'd0);
        check("t5.rst.checksum",  32'(checksum),  32'd0);
        tick();
        rrst_n = 1'b1;
        push(8'h81); push(8'h82); push(8'h83); push(8'h84);
        start_burst();
        run(12, nr, nd);
        check("t5.restart_pops", 32'(nr), 32'd4);
        check("t5.restart_done", 32'(nd), 32'd1);
        check("t5.restart_wc", 32'(word_cnt), 32'd4);
        check("t5.restart_data", 32'(out_data), 32'h84);

        // Test 6: start held through GAP and READ is ignored.
        push(8'h91); push(8'h92); push(8'h93); push(8'h94);
        start_burst();
        start = 1'b1;
        #1;
        nr = int'(rinc);
        nd = int'(done);
        tick();
        #1;
        nr += int'(rinc);
        nd += int'(done);
        tick();
        start = 1'b0;
        #1;
        nr += int'(rinc);
        nd += int'(done);
        run(12, nr2, nd2);
        check("t6.pops", 32'(nr + nr2), 32'd4);
        check("t6.done_pulses", 32'(nd + nd2), 32'd1);
        check("t6.word_cnt", 32'(word_cnt), 32'd4);
        check("t6.idle_after", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
